// File: rtl/neuron_tanh_divider_pkg.sv
// Shared definitions for the tanh activation divider: FSM encoding and Q-format constants.
package neuron_tanh_divider_pkg;

    localparam int WIDTH_DEF = 15;
    localparam int FRAC_DEF  = 13;
    localparam int ITER_DEF  = 14;

    localparam int ONE     = 1 <<< FRAC_DEF;
    localparam int SAT_MAX = ONE - 1;
    localparam int CNT_W   = $clog2(ITER_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest magnitude a result may take for a given number of fractional bits.
    function automatic int sat_limit(input int frac);
        return (1 <<< frac) - 1;
    endfunction

endpackage

// File: rtl/cordic_lin_vec_stage.sv
// One linear-vectoring CORDIC micro-rotation: drives y toward zero while z accumulates y/x.
module cordic_lin_vec_stage #(
    parameter int IW    = 18,
    parameter int FRAC  = 13,
    parameter int CNT_W = 4
) (
    input  logic signed [IW-1:0] i_x,
    input  logic signed [IW-1:0] i_y,
    input  logic signed [IW-1:0] i_z,
    input  logic [CNT_W-1:0]     i_idx,
    output logic signed [IW-1:0] o_y_next,
    output logic signed [IW-1:0] o_z_next
);

    logic                 w_d;
    logic signed [IW-1:0] w_xs;
    logic signed [IW-1:0] w_one;
    logic signed [IW-1:0] w_step;
    int                   w_shamt;

    assign w_d     = ~i_y[IW-1];
    assign w_xs    = i_x >>> i_idx;
    assign w_one   = {{(IW-1){1'b0}}, 1'b1};
    assign w_shamt = FRAC - int'(i_idx);
    assign w_step  = w_one <<< w_shamt;

    assign o_y_next = w_d ? (i_y - w_xs)   : (i_y + w_xs);
    assign o_z_next = w_d ? (i_z + w_step) : (i_z - w_step);

endmodule

// File: rtl/neuron_tanh_divider.sv
// Activation stage: tanh = sinh/cosh via iterative CORDIC division, or raw linear-sum bypass,
// presented on a valid/ready output.
module neuron_tanh_divider
    import neuron_tanh_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               af_en,
    input  logic signed [WIDTH:0] sin_h,
    input  logic signed [WIDTH:0] cos_h,
    input  logic signed [WIDTH:0] lin_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [WIDTH:0] act_out,
    output logic               err
);

    localparam int IW = WIDTH + 3;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]        LAST   = CW'(ITER - 1);
    localparam logic signed [IW-1:0] SAT_HI = IW'(sat_limit(FRAC));
    localparam logic signed [IW-1:0] SAT_LO = -SAT_HI;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_in_valid_q;
    logic                 r_err;
    logic signed [WIDTH:0] r_act;
    logic [CW-1:0]        r_cnt;
    logic signed [IW-1:0] r_x;
    logic signed [IW-1:0] r_y;
    logic signed [IW-1:0] r_z;

    logic                 w_start;
    logic                 w_cos_pos;
    logic                 w_err_set;
    logic                 w_load_ops;
    logic                 w_load_act;
    logic signed [WIDTH:0] w_act_nxt;
    logic signed [IW-1:0] w_y_nxt;
    logic signed [IW-1:0] w_z_nxt;

    function automatic logic signed [WIDTH:0] sat(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] c;
        c = v;
        if (v > SAT_HI) begin
            c = SAT_HI;
        end else if (v < SAT_LO) begin
            c = SAT_LO;
        end
        return (WIDTH+1)'(c);
    endfunction

    assign w_start   = in_valid & ~r_in_valid_q;
    assign w_cos_pos = ~cos_h[WIDTH] & (cos_h != '0);

    cordic_lin_vec_stage #(
        .IW    (IW),
        .FRAC  (FRAC),
        .CNT_W (CW)
    ) u_stage (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_z      (r_z),
        .i_idx    (r_cnt),
        .o_y_next (w_y_nxt),
        .o_z_next (w_z_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_load_ops  = 1'b0;
        w_load_act  = 1'b0;
        w_act_nxt   = r_act;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (!af_en) begin
                        w_load_act  = 1'b1;
                        w_act_nxt   = lin_in;
                        w_state_nxt = ST_DONE;
                    end else if (w_cos_pos) begin
                        w_load_ops  = 1'b1;
                        w_state_nxt = ST_ITER;
                    end else begin
                        w_load_act  = 1'b1;
                        w_act_nxt   = '0;
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_ITER: begin
                w_err_set = w_start;
                if (r_cnt == LAST) begin
                    w_load_act  = 1'b1;
                    w_act_nxt   = sat(w_z_nxt);
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_err_set = w_start;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control and the visible result register: cleared asynchronously so an abort shows nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_in_valid_q <= 1'b0;
            r_err        <= 1'b0;
            r_act        <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_valid_q <= in_valid;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_load_act) begin
                r_act <= w_act_nxt;
            end
            if (r_state == ST_ITER) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Datapath operands: no reset needed, always loaded before use.
    always_ff @(posedge clk) begin
        if (w_load_ops) begin
            r_x <= {{2{cos_h[WIDTH]}}, cos_h};
            r_y <= {{2{sin_h[WIDTH]}}, sin_h};
            r_z <= '0;
        end else if (r_state == ST_ITER) begin
            r_y <= w_y_nxt;
            r_z <= w_z_nxt;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign act_out   = r_act;
    assign err       = r_err;

endmodule

// File: tb/tb_neuron_tanh_divider.sv
// Directed plus randomized bench for neuron_tanh_divider against a real-arithmetic tanh model.
module tb_neuron_tanh_divider;

    localparam int WIDTH = 15;
    localparam int FRAC  = 13;
    localparam int ITER  = 14;
    localparam int SATV  = (1 <<< FRAC) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  af_en;
    logic                  out_ready;
    logic signed [WIDTH:0] sin_h;
    logic signed [WIDTH:0] cos_h;
    logic signed [WIDTH:0] lin_in;
    logic                  busy;
    logic                  out_valid;
    logic signed [WIDTH:0] act_out;
    logic                  err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_tanh_divider #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ITER  (ITER)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .af_en     (af_en),
        .sin_h     (sin_h),
        .cos_h     (cos_h),
        .lin_in    (lin_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act_out   (act_out),
        .err       (err)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        total++;
        assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Ideal tanh quotient in the output Q format, rounded and clamped to the legal range.
    function automatic int ref_tanh(input int s, input int c);
        real r;
        int  e;
        r = real'(s) * real'(1 <<< FRAC) / real'(c);
        e = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
        if (e > SATV)  e = SATV;
        if (e < -SATV) e = -SATV;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k = edges from raising in_valid until out_valid (the first of them is the start edge); 0 on timeout.
    task automatic run_op(input bit af, input int s, input int c, input int l,
                          output int k, output int act);
        af_en    = af;
        sin_h    = (WIDTH+1)'(s);
        cos_h    = (WIDTH+1)'(c);
        lin_in   = (WIDTH+1)'(l);
        in_valid = 1'b1;
        k        = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid) begin
                k = n;
                break;
            end
        end
        act      = int'(act_out);
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int k;
        int a;
        int s;
        int c;
        int l;
        int cnt;
        bit af;

        reset     = 1'b0;
        in_valid  = 1'b0;
        af_en     = 1'b1;
        out_ready = 1'b1;
        sin_h     = '0;
        cos_h     = '0;
        lin_in    = '0;
        repeat (2) tick();
        check("rst_busy", int'(busy), 0, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_act_out", int'(act_out), 0, 0);
        check("rst_err", int'(err), 0, 0);
        reset = 1'b1;
        tick();

        run_op(1'b1, 4269, 9238, 0, k, a);
        check("lat_tanh_half", k, ITER + 1, 0);
        check("tanh_half", a, 3786, 2);
        check("idle_after_accept", int'(busy), 0, 0);

        run_op(1'b1, -9627, 12641, 0, k, a);
        check("tanh_minus_one", a, -6239, 2);
        check("err_clean_neg", int'(err), 0, 0);

        run_op(1'b1, 8192, 8192, 0, k, a);
        check("tanh_ratio_one_sat", a, SATV, 0);

        run_op(1'b1, 0, 8192, 0, k, a);
        check("tanh_zero", a, 0, 1);

        run_op(1'b0, 0, 0, -1234, k, a);
        check("lat_bypass", k, 1, 0);
        check("bypass_value", a, -1234, 0);

        for (int n = 0; n < 24; n++) begin
            af = ($urandom_range(3) != 0);
            c  = int'($urandom_range(16383, 8192));
            s  = int'($urandom_range(2 * c - 2)) - (c - 1);
            l  = int'($urandom_range(65535)) - 32768;
            run_op(af, s, c, l, k, a);
            if (af) begin
                check("rand_lat_tanh", k, ITER + 1, 0);
                check("rand_tanh", a, ref_tanh(s, c), 6);
            end else begin
                check("rand_lat_bypass", k, 1, 0);
                check("rand_bypass", a, l, 0);
            end
        end
        check("err_clean_random", int'(err), 0, 0);

        af_en    = 1'b1;
        sin_h    = 16'sd2000;
        cos_h    = 16'sd10000;
        in_valid = 1'b1;
        cnt      = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (out_valid) cnt++;
        end
        in_valid = 1'b0;
        tick();
        check("held_in_valid_one_result", cnt, 1, 0);
        check("held_in_valid_value", int'(act_out), ref_tanh(2000, 10000), 2);

        run_op(1'b1, 1000, 0, 0, k, a);
        check("cos_zero_lat", k, 1, 0);
        check("cos_zero_act", a, 0, 0);
        check("cos_zero_err", int'(err), 1, 0);
        run_op(1'b1, 1000, -50, 0, k, a);
        check("cos_neg_lat", k, 1, 0);
        check("cos_neg_act", a, 0, 0);

        reset = 1'b0;
        #1;
        check("async_err_clear", int'(err), 0, 0);
        tick();
        reset = 1'b1;
        tick();

        out_ready = 1'b0;
        run_op(1'b1, 4269, 9238, 0, k, a);
        check("stall_value", a, 3786, 2);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (n == 10) in_valid = 1'b1;
            if (n == 12) in_valid = 1'b0;
            tick();
            if (!out_valid || int'(act_out) != a) cnt++;
        end
        check("stall_stable", cnt, 0, 0);
        check("stall_start_err", int'(err), 1, 0);
        check("stall_busy", int'(busy), 1, 0);
        out_ready = 1'b1;
        tick();
        check("release_out_valid", int'(out_valid), 0, 0);
        check("release_busy", int'(busy), 0, 0);

        af_en    = 1'b1;
        sin_h    = 16'sd4269;
        cos_h    = 16'sd9238;
        in_valid = 1'b1;
        tick();
        repeat (7) tick();
        check("mid_iter_busy", int'(busy), 1, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0, 0);
        check("abort_out_valid", int'(out_valid), 0, 0);
        check("abort_act_out", int'(act_out), 0, 0);
        check("abort_err", int'(err), 0, 0);
        tick();
        reset = 1'b1;
        tick();

        run_op(1'b1, -9627, 12641, 0, k, a);
        check("post_abort_lat", k, ITER + 1, 0);
        check("post_abort_tanh", a, -6239, 2);
        check("post_abort_err", int'(err), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
